// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU operand stage.
// Holds the ALU control codes, the R-type opcode and the funct encodings.
package alu_pkg;

   typedef logic [2:0] alu_ctrl_t;

   localparam alu_ctrl_t ALU_NOP = 3'b000;
   localparam alu_ctrl_t ALU_ADD = 3'b001;
   localparam alu_ctrl_t ALU_SUB = 3'b010;
   localparam alu_ctrl_t ALU_SLT = 3'b011;
   localparam alu_ctrl_t ALU_AND = 3'b100;
   localparam alu_ctrl_t ALU_OR  = 3'b101;
   localparam alu_ctrl_t ALU_XOR = 3'b110;
   localparam alu_ctrl_t ALU_NOR = 3'b111;

   localparam logic [5:0] OPC_RTYPE  = 6'h00;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_XOR = 6'h26;
   localparam logic [5:0] FUNCT_NOR = 6'h27;

endpackage

// File: rtl/alu_operand_stage_regfile.sv
// regfile_2r1w: NREGS x XLEN register file, 2 async reads, 1 sync write.
// Ports: clk, rst_n (sync, active low), i_we/i_waddr/i_wdata write port,
// i_ra1/i_ra2 read indices, o_rd1/o_rd2 read data. Index 0 reads as zero.
// Macro ALU_OPERAND_WB_BYPASS_EN forwards a same-cycle write to the reads.
module regfile_2r1w
   import alu_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int XLEN  = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [AW-1:0]   i_ra1,
   input  logic [AW-1:0]   i_ra2,
   output logic [XLEN-1:0] o_rd1,
   output logic [XLEN-1:0] o_rd2
);

   logic [XLEN-1:0] r_mem [NREGS];
   logic [XLEN-1:0] w_rd1;
   logic [XLEN-1:0] w_rd2;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0)) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Zero-index check comes last so r0 wins over any bypass.
   always_comb begin
      w_rd1 = r_mem[i_ra1];
      w_rd2 = r_mem[i_ra2];
`ifdef ALU_OPERAND_WB_BYPASS_EN
      if (i_we && (i_waddr == i_ra1)) w_rd1 = i_wdata;
      if (i_we && (i_waddr == i_ra2)) w_rd2 = i_wdata;
`endif
      if (i_ra1 == '0) w_rd1 = '0;
      if (i_ra2 == '0) w_rd2 = '0;
   end

   assign o_rd1 = w_rd1;
   assign o_rd2 = w_rd2;

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: R-type decode and operand fetch ahead of the ALU.
// In: clk, rst_n, in_valid/instr, flush, wb_en/wb_addr/wb_data, out_ready.
// Out: in_ready, out_valid, DR1, DR2, ALUControl, rd, illegal.
// Macro ALU_OPERAND_WB_BYPASS_EN enables write-back to operand bypass.
module alu_operand_stage
   import alu_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic            flush,
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] DR1,
   output logic [XLEN-1:0] DR2,
   output logic [2:0]      ALUControl,
   output logic [4:0]      rd,
   output logic            illegal
);

   logic [5:0]      w_opc;
   logic [4:0]      w_rs;
   logic [4:0]      w_rt;
   logic [4:0]      w_rd;
   logic [5:0]      w_funct;
   logic            w_unused_shamt;
   logic [XLEN-1:0] w_rd1;
   logic [XLEN-1:0] w_rd2;
   alu_ctrl_t       w_ctrl;
   logic            w_illegal;
   logic            w_accept;

   logic            r_valid;
   logic [XLEN-1:0] r_dr1;
   logic [XLEN-1:0] r_dr2;
   alu_ctrl_t       r_ctrl;
   logic [4:0]      r_rd;
   logic            r_illegal;

   assign w_opc          = instr[31:26];
   assign w_rs           = instr[25:21];
   assign w_rt           = instr[20:16];
   assign w_rd           = instr[15:11];
   assign w_funct        = instr[5:0];
   assign w_unused_shamt = ^instr[10:6];

   regfile_2r1w #(
      .NREGS (NREGS),
      .XLEN  (XLEN),
      .AW    (5)
   ) u_rf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (wb_en),
      .i_waddr (wb_addr),
      .i_wdata (wb_data),
      .i_ra1   (w_rs),
      .i_ra2   (w_rt),
      .o_rd1   (w_rd1),
      .o_rd2   (w_rd2)
   );

   always_comb begin
      w_ctrl    = ALU_NOP;
      w_illegal = 1'b1;
      if (w_opc == OPC_RTYPE) begin
         w_illegal = 1'b0;
         unique case (w_funct)
            FUNCT_ADD: w_ctrl = ALU_ADD;
            FUNCT_SUB: w_ctrl = ALU_SUB;
            FUNCT_SLT: w_ctrl = ALU_SLT;
            FUNCT_AND: w_ctrl = ALU_AND;
            FUNCT_OR:  w_ctrl = ALU_OR;
            FUNCT_XOR: w_ctrl = ALU_XOR;
            FUNCT_NOR: w_ctrl = ALU_NOR;
            default:   w_illegal = 1'b1;
         endcase
      end
   end

   // Single output register: a new entry may enter as the old one leaves.
   assign in_ready = !r_valid || out_ready;
   assign w_accept = in_valid && in_ready && !flush;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_dr1     <= '0;
         r_dr2     <= '0;
         r_ctrl    <= ALU_NOP;
         r_rd      <= '0;
         r_illegal <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid   <= 1'b1;
         r_dr1     <= w_rd1;
         r_dr2     <= w_rd2;
         r_ctrl    <= w_ctrl;
         r_rd      <= w_rd;
         r_illegal <= w_illegal;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid  = r_valid;
   assign DR1        = r_dr1;
   assign DR2        = r_dr2;
   assign ALUControl = r_ctrl;
   assign rd         = r_rd;
   assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed and random checks of alu_operand_stage
// against a behavioural model of the register file and output entry.
module tb_alu_operand_stage;

`ifdef ALU_OPERAND_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        flush;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] DR1;
   logic [31:0] DR2;
   logic [2:0]  ALUControl;
   logic [4:0]  rd;
   logic        illegal;

   always #5 clk = ~clk;

   alu_operand_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .instr      (instr),
      .flush      (flush),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .DR1        (DR1),
      .DR2        (DR2),
      .ALUControl (ALUControl),
      .rd         (rd),
      .illegal    (illegal)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Reference state: architectural registers and the output entry.
   logic [31:0] m_regs [32];
   logic        m_v;
   logic [31:0] m_dr1, m_dr2;
   logic [2:0]  m_ctrl;
   logic [4:0]  m_rd;
   logic        m_ill;
   logic        last_ir;

   // funct -> ALU code table, in code order 1..7.
   logic [5:0] ftab [7] = '{6'h20, 6'h22, 6'h2A, 6'h24, 6'h25, 6'h26, 6'h27};

   function automatic logic [3:0] decode(input logic [31:0] ins);
      // returns {illegal, code}
      if (ins[31:26] != 6'h00) return 4'b1000;
      for (int k = 0; k < 7; k++)
         if (ins[5:0] == ftab[k]) return {1'b0, 3'(k + 1)};
      return 4'b1000;
   endfunction

   function automatic logic [31:0] rdreg(input logic [4:0] a, input logic we,
                                         input logic [4:0] wa,
                                         input logic [31:0] wd);
      if (a == 0) return 32'h0;
      if (BYP && we && wa == a) return wd;
      return m_regs[a];
   endfunction

   task automatic step(input logic rs, input logic iv, input logic [31:0] ins,
                       input logic fl, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ordy);
      logic       acc;
      logic [3:0] dec;
      rst_n = rs; in_valid = iv; instr = ins; flush = fl;
      wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
      #1;
      last_ir = in_ready;
      if (rs) check("in_ready", {31'b0, in_ready}, {31'b0, !m_v || ordy});
      @(posedge clk);
      if (!rs) begin
         foreach (m_regs[k]) m_regs[k] = '0;
         m_v = 0; m_dr1 = 0; m_dr2 = 0; m_ctrl = 0; m_rd = 0; m_ill = 0;
      end else begin
         acc = iv && (!m_v || ordy) && !fl;
         if (acc) begin
            dec    = decode(ins);
            m_dr1  = rdreg(ins[25:21], we, wa, wd);
            m_dr2  = rdreg(ins[20:16], we, wa, wd);
            m_ctrl = dec[2:0];
            m_ill  = dec[3];
            m_rd   = ins[15:11];
         end
         if (we && wa != 0) m_regs[wa] = wd;
         if (fl) m_v = 0;
         else if (acc) m_v = 1;
         else if (ordy) m_v = 0;
      end
      @(negedge clk);
      check("out_valid", {31'b0, out_valid}, {31'b0, m_v});
      check("DR1", DR1, m_dr1);
      check("DR2", DR2, m_dr2);
      check("ALUControl", {29'b0, ALUControl}, {29'b0, m_ctrl});
      check("rd", {27'b0, rd}, {27'b0, m_rd});
      check("illegal", {31'b0, illegal}, {31'b0, m_ill});
   endtask

   function automatic logic [31:0] rtype(input int s, input int t,
                                         input int d, input logic [5:0] f);
      return {6'h00, 5'(s), 5'(t), 5'(d), 5'h00, f};
   endfunction

   initial begin
      logic [31:0] ins;
      logic [5:0]  f;
      foreach (m_regs[k]) m_regs[k] = 'x;
      m_v = 0; m_dr1 = 0; m_dr2 = 0; m_ctrl = 0; m_rd = 0; m_ill = 0;
      @(negedge clk);

      // Reset with a pending instruction.
      step(0, 1, 32'h0022_1820, 0, 0, 0, 0, 1);
      step(0, 1, 32'h0022_1820, 0, 0, 0, 0, 1);
      check("rst_valid", {31'b0, out_valid}, 32'h0);
      check("rst_dr1", DR1, 32'h0);
      check("rst_ctrl", {29'b0, ALUControl}, 32'h0);

      // Basic ADD.
      step(1, 0, 0, 0, 1, 1, 32'h5, 1);
      step(1, 0, 0, 0, 1, 2, 32'h3, 1);
      step(1, 1, 32'h0022_1820, 0, 0, 0, 0, 1);
      check("add_valid", {31'b0, out_valid}, 32'h1);
      check("add_dr1", DR1, 32'h5);
      check("add_dr2", DR2, 32'h3);
      check("add_ctrl", {29'b0, ALUControl}, 32'h1);
      check("add_rd", {27'b0, rd}, 32'h3);

      // Backpressure: sub r4,r2,r1 held off for 3 cycles.
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 32'h0041_2022, 0, (k == 1), 7, 32'h77, 0);
         check("bp_in_ready", {31'b0, last_ir}, 32'h0);
         check("bp_hold_dr1", DR1, 32'h5);
      end
      step(1, 1, 32'h0041_2022, 0, 0, 0, 0, 1);
      check("bp_dr1", DR1, 32'h3);
      check("bp_dr2", DR2, 32'h5);
      check("bp_ctrl", {29'b0, ALUControl}, 32'h2);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      check("bp_drain", {31'b0, out_valid}, 32'h0);

      // Illegal funct and zero register.
      step(1, 1, 32'h0020_0008, 0, 0, 0, 0, 1);
      check("ill_flag", {31'b0, illegal}, 32'h1);
      check("ill_ctrl", {29'b0, ALUControl}, 32'h0);
      check("ill_valid", {31'b0, out_valid}, 32'h1);
      step(1, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 1);
      step(1, 1, 32'h0001_2820, 0, 0, 0, 0, 1);
      check("r0_dr1", DR1, 32'h0);
      check("r0_dr2", DR2, 32'h5);

      // Same-cycle write-back and read of r1.
      step(1, 1, 32'h0022_3020, 0, 1, 1, 32'h1234, 1);
      check("byp_dr1", DR1, BYP ? 32'h1234 : 32'h5);

      // Flush while valid with a new instruction offered.
      step(1, 1, 32'h0022_3820, 1, 0, 0, 0, 1);
      check("flush_valid", {31'b0, out_valid}, 32'h0);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      check("flush_nocap", {31'b0, out_valid}, 32'h0);

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         f = ($urandom_range(0, 8) < 7) ? ftab[$urandom_range(0, 6)]
                                        : 6'($urandom);
         ins = rtype($urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), f);
         ins[10:6] = 5'($urandom);
         if ($urandom_range(0, 7) == 0) ins[31:26] = 6'($urandom);
         step(($urandom_range(0, 99) != 0), $urandom_range(0, 1), ins,
              ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
              5'($urandom), $urandom, ($urandom_range(0, 3) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
